// File: rtl/btn_debounce_sched_pkg.sv
// Shared constants for the button debounce scheduler: FSM encoding and
// synchronizer depth.
package btn_debounce_sched_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/btn_debounce_sched_settle_timer.sv
// Shared settle timer: counts while enabled, holds at SETTLE_CYC-1 and flags done.
module settle_timer #(
   parameter  int SETTLE_CYC = 500000,
   localparam int TW         = $clog2(SETTLE_CYC)
) (
   input  logic clk,
   input  logic rst_l,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !done) begin
         count_d = count_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == TW'(SETTLE_CYC - 1));

endmodule

// File: rtl/btn_debounce_sched.sv
// Debounce scheduler: N synchronized buttons share one settle timer, granted
// round-robin. Optional macro BTN_RELEASE_PULSE_EN adds btn_rel_pulse.
module btn_debounce_sched
   import btn_debounce_sched_pkg::*;
#(
   parameter  int N_BTN      = 4,
   parameter  int SETTLE_CYC = 500000,
   localparam int GW         = $clog2(N_BTN)
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
`ifdef BTN_RELEASE_PULSE_EN
   output logic [N_BTN-1:0] btn_rel_pulse,
`endif
   output logic             busy,
   output logic [GW-1:0]    grant_idx
);

   state_e           state_q, state_d;
   logic [N_BTN-1:0] sync_q [SYNC_STAGES];
   logic [N_BTN-1:0] sync;
   logic [N_BTN-1:0] req;
   logic [N_BTN-1:0] level_q, level_d;
   logic [N_BTN-1:0] pulse_q, pulse_d;
   logic [N_BTN-1:0] rel_q, rel_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    rr_q, rr_d;
   logic             timer_clear, timer_en, timer_done;
   logic             bounce;

   // First requesting index at or after ptr, wrapping; lower offsets win.
   function automatic logic [GW-1:0] rr_pick(input logic [N_BTN-1:0] r,
                                             input logic [GW-1:0]    ptr);
      logic [GW-1:0] pick;
      pick = ptr;
      for (int k = N_BTN - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % N_BTN;
         if (r[idx]) pick = GW'(idx);
      end
      return pick;
   endfunction

   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
      return (g == GW'(N_BTN - 1)) ? '0 : g + GW'(1);
   endfunction

   assign sync   = sync_q[SYNC_STAGES-1];
   assign req    = sync ^ level_q;
   assign bounce = (sync[grant_q] == level_q[grant_q]);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= IDLE;
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         level_q <= '0;
         pulse_q <= '0;
         rel_q   <= '0;
         grant_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q   <= state_d;
         sync_q[0] <= btn_raw;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         level_q <= level_d;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      timer_clear = 1'b1;
      timer_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = rr_pick(req, rr_q);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            timer_clear = 1'b0;
            if (bounce) begin
               state_d = IDLE;
               rr_d    = next_idx(grant_q);
            end else if (timer_done) begin
               state_d = COMMIT;
            end else begin
               timer_en = 1'b1;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            rr_d    = next_idx(grant_q);
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Level/pulse updates happen only on the COMMIT cycle of the granted button.
   always_comb begin
      level_d = level_q;
      pulse_d = '0;
      rel_d   = '0;
      busy    = (state_q != IDLE);
      case (state_q)
         COMMIT: begin
            level_d[grant_q] = sync[grant_q];
            pulse_d[grant_q] = sync[grant_q] & ~level_q[grant_q];
            rel_d[grant_q]   = ~sync[grant_q] & level_q[grant_q];
         end
         IDLE, SETTLE: begin
            level_d = level_q;
         end
         default: begin
            level_d = '0;
         end
      endcase
   end

   settle_timer #(
      .SETTLE_CYC(SETTLE_CYC)
   ) u_timer (
      .clk    (clk),
      .rst_l  (rst_l),
      .clear  (timer_clear),
      .enable (timer_en),
      .done   (timer_done)
   );

   assign btn_level = level_q;
   assign btn_pulse = pulse_q;
   assign grant_idx = grant_q;

`ifdef BTN_RELEASE_PULSE_EN
   assign btn_rel_pulse = rel_q;
`else
   logic unused_rel;
   assign unused_rel = ^rel_q;
`endif

endmodule

// File: tb/tb_btn_debounce_sched.sv
// Bench for btn_debounce_sched (N_BTN=4, SETTLE_CYC=8); expected commit events
// are queued by the stimulus and popped by a monitor on each output event.
module tb_btn_debounce_sched;

   localparam int N   = 4;
   localparam int SC  = 8;
   localparam int LAT = SC + 3;
`ifdef BTN_RELEASE_PULSE_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0]  edge_n;
      logic [N-1:0] level;
      logic [N-1:0] pulse;
      logic [N-1:0] rel;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst_l = 1'b0;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_pulse;
   logic         busy;
   logic [1:0]   grant_idx;
   logic [N-1:0] rel_act;
`ifdef BTN_RELEASE_PULSE_EN
   logic [N-1:0] btn_rel_pulse;
   assign rel_act = btn_rel_pulse;
`else
   assign rel_act = '0;
`endif

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   ev_t  exp_q[$];
   ev_t  mon_ev;
   logic [N-1:0] prev_level = '0;

   btn_debounce_sched #(
      .N_BTN      (N),
      .SETTLE_CYC (SC)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
`ifdef BTN_RELEASE_PULSE_EN
      .btn_rel_pulse (btn_rel_pulse),
`endif
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   // Clock and edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at edge %0d, expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
      end
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic drive(input logic [N-1:0] v, output int t0);
      @(negedge clk);
      btn_raw = v;
      t0 = cyc + 1;
   endtask

   task automatic push(input int e, input logic [N-1:0] lvl, input logic [N-1:0] pls,
                       input logic [N-1:0] rel);
      ev_t ev;
      ev.edge_n = 32'(e);
      ev.level  = lvl;
      ev.pulse  = pls;
      ev.rel    = rel;
      exp_q.push_back(ev);
   endtask

   // Monitor: any level change or pulse is an output event
   always @(negedge clk) begin
      if (!rst_l) begin
         prev_level = '0;
      end else if (btn_level != prev_level || btn_pulse != '0 || rel_act != '0) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got level %b pulse %b rel %b at edge %0d, expected none",
                     btn_level, btn_pulse, rel_act, cyc);
         end else begin
            mon_ev = exp_q.pop_front();
            check("event_edge", 32'(cyc), mon_ev.edge_n);
            check("event_level", 32'(btn_level), 32'(mon_ev.level));
            check("event_pulse", 32'(btn_pulse), 32'(mon_ev.pulse));
            check("event_rel_pulse", 32'(rel_act), 32'(mon_ev.rel));
         end
         prev_level = btn_level;
      end
   end

   initial begin
      int t0;
      int r;
      repeat (3) @(negedge clk);
      check("reset_level", 32'(btn_level), 32'(0));
      check("reset_pulse", 32'(btn_pulse), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_grant", 32'(grant_idx), 32'(0));
      rst_l = 1'b1;

      // Single press on button 1
      drive(4'b0010, t0);
      push(t0 + LAT, 4'b0010, 4'b0010, 4'b0000);
      wait_edge(t0 + 1);  check("t1_busy_e1", 32'(busy), 32'(0));
      wait_edge(t0 + 2);  check("t1_busy_e2", 32'(busy), 32'(1));
      check("t1_grant", 32'(grant_idx), 32'(1));
      wait_edge(t0 + 10); check("t1_busy_e10", 32'(busy), 32'(1));
      wait_edge(t0 + 11); check("t1_busy_e11", 32'(busy), 32'(0));
      wait_edge(t0 + 20);

      // Short glitch on button 2 aborts SETTLE
      drive(4'b0110, t0);
      wait_edge(t0 + 2);  check("t2_grant", 32'(grant_idx), 32'(2));
      wait_edge(t0 + 4);  btn_raw = 4'b0010;
      wait_edge(t0 + 6);  check("t2_busy_e6", 32'(busy), 32'(1));
      wait_edge(t0 + 7);  check("t2_busy_e7", 32'(busy), 32'(0));
      wait_edge(t0 + 20); check("t2_level", 32'(btn_level), 32'(4'b0010));

      // Release of button 1; search starts at rr_ptr=3
      drive(4'b0000, t0);
      push(t0 + LAT, 4'b0000, 4'b0000, REL_EN ? 4'b0010 : 4'b0000);
      wait_edge(t0 + 2);  check("t4_grant", 32'(grant_idx), 32'(1));
      wait_edge(t0 + LAT + 3);

      // Reset during SETTLE with button 0 held
      drive(4'b0001, t0);
      wait_edge(t0 + 6);
      rst_l = 1'b0;
      #1;
      check("t5_rst_level", 32'(btn_level), 32'(0));
      check("t5_rst_pulse", 32'(btn_pulse), 32'(0));
      check("t5_rst_busy", 32'(busy), 32'(0));
      check("t5_rst_grant", 32'(grant_idx), 32'(0));
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      r = cyc + 1;
      push(r + LAT, 4'b0001, 4'b0001, 4'b0000);
      wait_edge(r + LAT + 3);

      // Reset again with inputs low so rr_ptr restarts at 0
      @(negedge clk);
      btn_raw = '0;
      rst_l = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b1;

      // Buttons 0 and 3 together
      drive(4'b1001, t0);
      push(t0 + 11, 4'b0001, 4'b0001, 4'b0000);
      push(t0 + 21, 4'b1001, 4'b1000, 4'b0000);
      wait_edge(t0 + 5);  check("t3_grant_0", 32'(grant_idx), 32'(0));
      wait_edge(t0 + 12); check("t3_grant_3a", 32'(grant_idx), 32'(3));
      check("t3_busy", 32'(busy), 32'(1));
      wait_edge(t0 + 20); check("t3_grant_3b", 32'(grant_idx), 32'(3));
      wait_edge(t0 + 30);

      // Release both
      drive(4'b0000, t0);
      push(t0 + 11, 4'b1000, 4'b0000, REL_EN ? 4'b0001 : 4'b0000);
      push(t0 + 21, 4'b0000, 4'b0000, REL_EN ? 4'b1000 : 4'b0000);
      wait_edge(t0 + 30);

      // All four together, rr_ptr=0
      drive(4'b1111, t0);
      push(t0 + 11, 4'b0001, 4'b0001, 4'b0000);
      push(t0 + 21, 4'b0011, 4'b0010, 4'b0000);
      push(t0 + 31, 4'b0111, 4'b0100, 4'b0000);
      push(t0 + 41, 4'b1111, 4'b1000, 4'b0000);
      wait_edge(t0 + 50);

      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
